pipe_adder: RTL and testbench
=============================

Name: pipe_adder

Overview:
Parametrised, pipelined ripple-carry adder/subtractor with valid/ready handshake. Splits a WIDTH-bit add into STAGES register-separated carry chunks, so wide mantissa and address adds in the pipeline can close timing. Carries a sideband tag alongside the data and applies downstream backpressure stage by stage. Supersedes fixed-width combinational adders wherever a registered result is acceptable.

Parameters:
WIDTH, 24, operand and result width in bits (>=1).
STAGES, 3, pipeline depth and carry-chunk count (1..WIDTH).
TAG_W, 4, sideband tag width carried with each operation (>=1).

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  asynchronous active-low reset
flush_i  input  1  synchronous clear of all in-flight operations
in_valid_i  input  1  operands valid
in_ready_o  output  1  block can accept operands this cycle
a_i  input  WIDTH  operand A
b_i  input  WIDTH  operand B
cin_i  input  1  carry-in (add mode only)
sub_i  input  1  1 = A - B, 0 = A + B + cin
tag_i  input  TAG_W  sideband, returned unchanged
out_valid_o  output  1  result valid
out_ready_i  input  1  consumer accepts result
sum_o  output  WIDTH  result
cout_o  output  1  carry out of MSB (sub: 1 = no borrow)
tag_o  output  TAG_W  tag of the result

Behaviour:
- Reset (rst_ni low, async): all stage valid bits 0; out_valid_o=0, sum_o=0, cout_o=0, tag_o=0; all data registers 0. Release is synchronous to clk_i.
- Chunking: CHUNK = ceil(WIDTH/STAGES). Stage k (0-based) adds bits [k*CHUNK +: CHUNK], clipped to WIDTH. The last stage takes the remainder. If the remainder is 0, the trailing stages forward data unchanged.
- Operand conditioning at entry: B' = sub_i ? ~b_i : b_i; c0 = sub_i ? 1 : cin_i. cin_i is ignored when sub_i=1.
- Stage k registers:
  - its chunk sum;
  - carry into stage k+1;
  - unprocessed upper chunks of A and B';
  - already-computed lower sum chunks;
  - the tag.
- Result is exact modulo 2^WIDTH. cout_o is the carry out of bit WIDTH-1.
- Handshake:
  - Transfer in when in_valid_i && in_ready_o.
  - Transfer out when out_valid_o && out_ready_i.
  - Stage k advances if it is empty or stage k+1 advances. The last stage advances if it is empty or out_ready_i.
  - in_ready_o = stage-0 advance condition (combinational from out_ready_i; no combinational in_valid_i -> in_ready_o path).
- Latency exactly STAGES cycles from accepted input to out_valid_o when unstalled. Throughput 1 op/cycle. Order preserved.
- Backpressure:
  - out_ready_i=0 holds the last stage: sum_o, cout_o and tag_o stay stable while out_valid_o=1.
  - Bubbles ahead of the last stage still compress.
  - Full pipeline with out_ready_i=0: in_ready_o=0.
- Simultaneous events:
  - Full pipeline with out_ready_i=1 accepts a new input in the same cycle one leaves.
  - flush_i has priority over all transfers: every valid bit is cleared next edge, the input in that cycle is discarded, and in_ready_o is unaffected combinationally.
- Reset mid-operation discards all in-flight ops; no partial result ever appears.
- STAGES=1: single registered full-width add, latency 1.
- Outputs are registered; no combinational input->sum_o path.

Optional Feature:
Macro PIPE_ADDER_FLAGS_EN.
- Defined: adds outputs ovf_o (1), zero_o (1), neg_o (1), aligned with sum_o and reset to 0.
  - ovf_o: signed two's-complement overflow, computed as carry into MSB XOR carry out of MSB.
  - zero_o: sum_o==0.
  - neg_o: sum_o[WIDTH-1].
- Undefined: ports absent, no flag logic; datapath timing identical.

Test Plan:
- WIDTH=24, STAGES=3, single add A=0x00FFFF, B=0x000001, cin=0, tag=0x5, out_ready=1 -> exactly 3 cycles later sum=0x010000, cout=0, tag=0x5 (carry crosses the stage-1/stage-2 chunk boundary).
- Subtract A=0x000000, B=0x000001 -> sum=0xFFFFFF, cout=0; with flags enabled, neg=1, ovf=0, zero=0. Add A=0x7FFFFF, B=0x000001 -> sum=0x800000, ovf=1.
- Back-to-back stream of 8 ops (A=i, B=0x100000*i, tag=i), out_ready=1 -> 8 consecutive valid results in order, one per cycle, in_ready constantly 1.
- Fill pipeline, hold out_ready=0 for 5 cycles -> in_ready=0 after 3 accepts, sum_o/tag_o stable; release -> all 3 drain in order, with no loss or duplicates.
- Flush with 2 ops in flight plus an input offered in the same cycle -> no out_valid for those ops, the next op after flush gets normal 3-cycle latency.
- Assert rst_ni low mid-stream, asynchronously between edges -> out_valid_o and all outputs 0 immediately. Repeat the add/sub checks at STAGES=1 and STAGES=24 with WIDTH=24 -> identical results, latency 1 and 24 respectively.

Source files
------------

// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - pipelined ripple-carry adder/subtractor with valid/ready handshake
//
// Purpose:
//   Splits a WIDTH-bit add into STAGES register-separated carry chunks of
//   CHUNK = ceil(WIDTH/STAGES) bits. Stage k adds bits [k*CHUNK +: CHUNK],
//   clipped to WIDTH. Stages whose chunk lies wholly above WIDTH forward their
//   data unchanged. A sideband tag travels with each operation. Backpressure
//   is applied stage by stage, so bubbles compress while the output is held.
//
//   Optional feature macro: PIPE_ADDER_FLAGS_EN adds the ovf_o, zero_o and
//   neg_o flag outputs. They are registered alongside sum_o.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   flush_i      synchronous clear of all in-flight operations
//   in_valid_i   operands valid
//   in_ready_o   block can accept operands this cycle
//   a_i, b_i     operands A and B (WIDTH bits)
//   cin_i        carry-in; ignored when sub_i=1
//   sub_i        1 = A - B, 0 = A + B + cin
//   tag_i        sideband, returned unchanged in tag_o
//   out_valid_o  result valid
//   out_ready_i  consumer accepts result
//   sum_o        result modulo 2^WIDTH
//   cout_o       carry out of the MSB (subtract: 1 = no borrow)
//   tag_o        tag of the result
//   ovf_o        (flags only) signed two's-complement overflow
//   zero_o       (flags only) sum_o == 0
//   neg_o        (flags only) sum_o[WIDTH-1]

module pipe_adder #(
  parameter int WIDTH  = 24,
  parameter int STAGES = 3,
  parameter int TAG_W  = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic [TAG_W-1:0] tag_o
`ifdef PIPE_ADDER_FLAGS_EN
  ,
  output logic             ovf_o,
  output logic             zero_o,
  output logic             neg_o
`endif
);

  localparam int CHUNK = (WIDTH + STAGES - 1) / STAGES;

  // Mask selecting bits [lo, lo+len) of a WIDTH-bit word.
  function automatic logic [WIDTH-1:0] chunk_mask(input int lo, input int len);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i >= lo && i < lo + len) begin
        m[i] = 1'b1;
      end
    end
    return m;
  endfunction

  // One valid bit per stage, gathered so each stage can see the occupancy of
  // everything downstream of it.
  logic [STAGES-1:0] valid_w;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO  = k * CHUNK;
    localparam int LEN = (LO >= WIDTH) ? 0 :
                         ((WIDTH - LO < CHUNK) ? (WIDTH - LO) : CHUNK);

    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] s_in;
    logic             c_in;
    logic             v_in;
    logic [TAG_W-1:0] t_in;

    logic [WIDTH-1:0] s_d;
    logic             c_d;
    logic             adv;

    logic [WIDTH-1:0] s_q;
    logic             c_q;
    logic             v_q;
    logic [TAG_W-1:0] t_q;

    // Stage 0 conditions the operands: subtract is A + ~B + 1.
    if (k == 0) begin : g_src
      assign a_in = a_i;
      assign b_in = sub_i ? ~b_i : b_i;
      assign c_in = sub_i | cin_i;
      assign s_in = '0;
      assign v_in = in_valid_i;
      assign t_in = tag_i;
    end else begin : g_src
      assign a_in = g_stage[k-1].g_fwd.a_q;
      assign b_in = g_stage[k-1].g_fwd.b_q;
      assign c_in = g_stage[k-1].c_q;
      assign s_in = g_stage[k-1].s_q;
      assign v_in = g_stage[k-1].v_q;
      assign t_in = g_stage[k-1].t_q;
    end

    if (LEN > 0) begin : g_add
      localparam logic [WIDTH-1:0] MASK = chunk_mask(LO, LEN);
      localparam logic [WIDTH:0]   CSEL = (WIDTH+1)'(1) << (LO + LEN);
      logic [WIDTH:0] add_full;
      // Operands outside the chunk are masked to zero, so the carry out of the
      // chunk lands exactly on bit LO+LEN of the widened sum.
      assign add_full = {1'b0, a_in & MASK} + {1'b0, b_in & MASK}
                      + ((WIDTH+1)'(c_in) << LO);
      assign s_d = (s_in & ~MASK) | (add_full[WIDTH-1:0] & MASK);
      assign c_d = |(add_full & CSEL);
    end else begin : g_add
      assign s_d = s_in;
      assign c_d = c_in;
    end

    // A stage may take new data when it or any stage downstream has a bubble,
    // or when the consumer is taking the result.
    assign adv        = out_ready_i | ~(&valid_w[STAGES-1:k]);
    assign valid_w[k] = v_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        v_q <= 1'b0;
        s_q <= '0;
        c_q <= 1'b0;
        t_q <= '0;
      end else begin
        if (flush_i) begin
          v_q <= 1'b0;
        end else if (adv) begin
          v_q <= v_in;
        end
        if (adv && v_in && !flush_i) begin
          s_q <= s_d;
          c_q <= c_d;
          t_q <= t_in;
        end
      end
    end

    // Operands are needed only by the stages that still have chunks to add.
    if (k < STAGES - 1) begin : g_fwd
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv && v_in && !flush_i) begin
          a_q <= a_in;
          b_q <= b_in;
        end
      end
    end

`ifdef PIPE_ADDER_FLAGS_EN
    if (k == STAGES - 1) begin : g_flags
      logic ovf_q;
      logic zero_q;
      logic neg_q;
      logic msb_cin;
      // The carry into the MSB is recovered from the MSB sum bit and its operands.
      assign msb_cin = a_in[WIDTH-1] ^ b_in[WIDTH-1] ^ s_d[WIDTH-1];
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
          neg_q  <= 1'b0;
        end else if (adv && v_in && !flush_i) begin
          ovf_q  <= msb_cin ^ c_d;
          zero_q <= (s_d == '0);
          neg_q  <= s_d[WIDTH-1];
        end
      end
    end
`endif
  end

  assign in_ready_o  = g_stage[0].adv;
  assign out_valid_o = g_stage[STAGES-1].v_q;
  assign sum_o       = g_stage[STAGES-1].s_q;
  assign cout_o      = g_stage[STAGES-1].c_q;
  assign tag_o       = g_stage[STAGES-1].t_q;

`ifdef PIPE_ADDER_FLAGS_EN
  assign ovf_o  = g_stage[STAGES-1].g_flags.ovf_q;
  assign zero_o = g_stage[STAGES-1].g_flags.zero_q;
  assign neg_o  = g_stage[STAGES-1].g_flags.neg_q;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// tb/tb_pipe_adder.sv - directed self-checking bench for pipe_adder at STAGES 3, 1 and 24
module tb_pipe_adder;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [23:0] a;
  logic [23:0] b;
  logic        cin;
  logic        sub;
  logic [3:0]  tag;
  logic        out_ready;

  logic        in_ready_s3, out_valid_s3, cout_s3;
  logic [23:0] sum_s3;
  logic [3:0]  tag_s3;
  logic        in_ready_s1, out_valid_s1, cout_s1;
  logic [23:0] sum_s1;
  logic [3:0]  tag_s1;
  logic        in_ready_s24, out_valid_s24, cout_s24;
  logic [23:0] sum_s24;
  logic [3:0]  tag_s24;
`ifdef PIPE_ADDER_FLAGS_EN
  logic ovf_s3, zero_s3, neg_s3;
  logic ovf_s1, zero_s1, neg_s1;
  logic ovf_s24, zero_s24, neg_s24;
`endif

  int checks   = 0;
  int failures = 0;

  pipe_adder #(.WIDTH(24), .STAGES(3), .TAG_W(4)) u_s3 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(in_ready_s3), .a_i(a), .b_i(b), .cin_i(cin), .sub_i(sub),
    .tag_i(tag), .out_valid_o(out_valid_s3), .out_ready_i(out_ready),
    .sum_o(sum_s3), .cout_o(cout_s3), .tag_o(tag_s3)
`ifdef PIPE_ADDER_FLAGS_EN
    , .ovf_o(ovf_s3), .zero_o(zero_s3), .neg_o(neg_s3)
`endif
  );

  pipe_adder #(.WIDTH(24), .STAGES(1), .TAG_W(4)) u_s1 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(in_ready_s1), .a_i(a), .b_i(b), .cin_i(cin), .sub_i(sub),
    .tag_i(tag), .out_valid_o(out_valid_s1), .out_ready_i(out_ready),
    .sum_o(sum_s1), .cout_o(cout_s1), .tag_o(tag_s1)
`ifdef PIPE_ADDER_FLAGS_EN
    , .ovf_o(ovf_s1), .zero_o(zero_s1), .neg_o(neg_s1)
`endif
  );

  pipe_adder #(.WIDTH(24), .STAGES(24), .TAG_W(4)) u_s24 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(in_ready_s24), .a_i(a), .b_i(b), .cin_i(cin), .sub_i(sub),
    .tag_i(tag), .out_valid_o(out_valid_s24), .out_ready_i(out_ready),
    .sum_o(sum_s24), .cout_o(cout_s24), .tag_o(tag_s24)
`ifdef PIPE_ADDER_FLAGS_EN
    , .ovf_o(ovf_s24), .zero_o(zero_s24), .neg_o(neg_s24)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_dut(input string name, input int n, input int lat,
                           input logic v, input logic [23:0] s, input logic c,
                           input logic [3:0] t, input logic [23:0] es,
                           input logic ec, input logic [3:0] et);
    if (n == lat) begin
      check({name, "_valid"}, v, 1);
      check({name, "_sum"}, s, es);
      check({name, "_cout"}, c, ec);
      check({name, "_tag"}, t, et);
    end else if (n == lat - 1 || n == lat + 1) begin
      check({name, "_valid_idle"}, v, 0);
    end
  endtask

  // One operation offered for a single cycle to all three depths; each
  // result must appear exactly STAGES cycles after presentation.
  task automatic single_op(input logic [23:0] ia, input logic [23:0] ib,
                           input logic icin, input logic isub, input logic [3:0] itag,
                           input logic [23:0] es, input logic ec,
                           input logic eovf, input logic ezero, input logic eneg);
    a = ia; b = ib; cin = icin; sub = isub; tag = itag; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int n = 1; n <= 25; n++) begin
      check_dut("s3", n, 3, out_valid_s3, sum_s3, cout_s3, tag_s3, es, ec, itag);
      check_dut("s1", n, 1, out_valid_s1, sum_s1, cout_s1, tag_s1, es, ec, itag);
      check_dut("s24", n, 24, out_valid_s24, sum_s24, cout_s24, tag_s24, es, ec, itag);
`ifdef PIPE_ADDER_FLAGS_EN
      if (n == 3) begin
        check("s3_ovf", ovf_s3, eovf);
        check("s3_zero", zero_s3, ezero);
        check("s3_neg", neg_s3, eneg);
      end
`else
      if (n == 3 && (eovf | ezero | eneg) === 1'bx) begin
        check("flag_vector_known", 0, 1);
      end
`endif
      if (n < 25) step();
    end
  endtask

  initial begin
    int acc;
    logic exp_v;
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; a = '0; b = '0;
    cin = 1'b0; sub = 1'b0; tag = '0; out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid_s3, 0);
    check("rst_sum", sum_s3, 0);
    check("rst_cout", cout_s3, 0);
    check("rst_tag", tag_s3, 0);
    check("rst_in_ready", in_ready_s3, 1);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Directed add/sub vectors: {a, b, cin, sub, tag} -> {sum, cout, ovf, zero, neg}
    single_op(24'h00FFFF, 24'h000001, 1'b0, 1'b0, 4'h5, 24'h010000, 1'b0, 1'b0, 1'b0, 1'b0);
    single_op(24'h000000, 24'h000001, 1'b1, 1'b1, 4'h6, 24'hFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    single_op(24'h7FFFFF, 24'h000001, 1'b0, 1'b0, 4'h7, 24'h800000, 1'b0, 1'b1, 1'b0, 1'b1);
    single_op(24'hFFFFFF, 24'h000000, 1'b1, 1'b0, 4'h8, 24'h000000, 1'b1, 1'b0, 1'b1, 1'b0);
    single_op(24'h000005, 24'h000003, 1'b0, 1'b1, 4'h9, 24'h000002, 1'b1, 1'b0, 1'b0, 1'b0);

    // Back-to-back stream of 8 ops; result i = i * 0x100001.
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc < 8) begin
        in_valid = 1'b1; a = 24'(cyc); b = 24'h100000 * 24'(cyc);
        tag = 4'(cyc); cin = 1'b0; sub = 1'b0;
        check("stream_in_ready", in_ready_s3, 1);
      end else begin
        in_valid = 1'b0;
      end
      step();
      exp_v = (cyc >= 2) && (cyc <= 9);
      check("stream_valid", out_valid_s3, exp_v);
      if (exp_v) begin
        check("stream_sum", sum_s3, 32'h100001 * (cyc - 2));
        check("stream_tag", tag_s3, cyc - 2);
      end
    end

    // Backpressure: consumer stalled for 5 cycles.
    out_ready = 1'b0;
    acc = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      in_valid = 1'b1; a = 24'h10 + 24'(acc); b = '0; tag = 4'(acc);
      check("bp_in_ready", in_ready_s3, (acc < 3) ? 1 : 0);
      if (in_ready_s3) acc++;
      step();
      if (cyc >= 2) begin
        check("bp_hold_valid", out_valid_s3, 1);
        check("bp_hold_sum", sum_s3, 32'h10);
        check("bp_hold_tag", tag_s3, 0);
      end
    end
    check("bp_accepts", acc, 3);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k < 3) begin
        check("drain_valid", out_valid_s3, 1);
        check("drain_sum", sum_s3, 32'h10 + k);
        check("drain_tag", tag_s3, k);
      end else begin
        check("drain_empty", out_valid_s3, 0);
      end
      step();
    end

    // Flush with two ops in flight and a third offered in the flush cycle.
    in_valid = 1'b1; a = 24'h1; b = 24'h1; tag = 4'h1;
    step();
    a = 24'h2; b = 24'h2; tag = 4'h2;
    step();
    flush = 1'b1; a = 24'h3; tag = 4'h3;
    check("flush_in_ready", in_ready_s3, 1);
    step();
    flush = 1'b0;
    check("flush_cleared", out_valid_s3, 0);
    a = 24'h123456; b = 24'h111111; tag = 4'h4;
    step();
    in_valid = 1'b0;
    for (int e = 4; e <= 7; e++) begin
      check("post_flush_valid", out_valid_s3, (e == 6) ? 1 : 0);
      if (e == 6) begin
        check("post_flush_sum", sum_s3, 32'h234567);
        check("post_flush_tag", tag_s3, 4'h4);
      end
      if (e < 7) step();
    end

    // Asynchronous reset between edges while a result is being presented.
    out_ready = 1'b0;
    in_valid = 1'b1; a = 24'h1; b = 24'h2; tag = 4'h7;
    step();
    in_valid = 1'b0;
    step();
    step();
    check("pre_reset_valid", out_valid_s3, 1);
    check("pre_reset_sum", sum_s3, 3);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid_s3, 0);
    check("async_rst_sum", sum_s3, 0);
    check("async_rst_tag", tag_s3, 0);
    check("async_rst_cout", cout_s3, 0);
    check("async_rst_valid_s24", out_valid_s24, 0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("post_rst_no_result", out_valid_s3, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
